// File: rtl/mem_wb_stage_pkg.sv
// Shared types and defaults for the MEM/WB pipeline register.
// FSM encoding, default widths and the hard-wired zero register index.
package mem_wb_stage_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  localparam int DEF_NB_DATA  = 32;
  localparam int DEF_NB_REG   = 5;
  localparam int DEF_NB_COUNT = 32;

  localparam int ZERO_REG_IDX = 0;

endpackage

// File: rtl/mem_wb_stage_wb_load_extend.sv
// Combinational sub-word load extender: byte beats halfword, otherwise the
// word passes through. zero_ext selects LBU/LHU behaviour.
module wb_load_extend #(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] data,
  input  logic               byte_en,
  input  logic               halfword_en,
  input  logic               zero_ext,
  output logic [NB_DATA-1:0] ext_data
);

  logic b_fill, h_fill;

  assign b_fill = ~zero_ext & data[7];
  assign h_fill = ~zero_ext & data[15];

  always_comb begin
    ext_data = data;
    if (byte_en)
      ext_data = {{(NB_DATA-8){b_fill}}, data[7:0]};
    else if (halfword_en)
      ext_data = {{(NB_DATA-16){h_fill}}, data[15:0]};
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux, retire counter and halt FSM.
// Define WB_LOAD_EXT_EN to enable sub-word load sign/zero extension.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int NB_DATA  = DEF_NB_DATA,
  parameter int NB_REG   = DEF_NB_REG,
  parameter int NB_COUNT = DEF_NB_COUNT
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic                i_MEM_valid,
  input  logic                i_MEM_reg_write,
  input  logic                i_MEM_mem_to_reg,
  input  logic                i_MEM_byte_en,
  input  logic                i_MEM_halfword_en,
  input  logic                i_MEM_unsigned,
  input  logic                i_MEM_halt,
  input  logic [NB_DATA-1:0]  i_MEM_mem_data,
  input  logic [NB_DATA-1:0]  i_MEM_alu_result,
  input  logic [NB_REG-1:0]   i_MEM_selected_reg,
  output logic [NB_DATA-1:0]  o_WB_data,
  output logic [NB_REG-1:0]   o_WB_selected_reg,
  output logic                o_WB_reg_write,
  output logic                o_WB_valid,
  output logic                o_WB_halt,
  output logic [NB_COUNT-1:0] o_WB_retired
);

  wb_state_e state_q, state_d;
  logic capture, valid_in;

  logic                vld_q, reg_write_q, mem_to_reg_q;
  logic [NB_DATA-1:0]  mem_data_q, alu_result_q, mem_ext;
  logic [NB_REG-1:0]   sel_q;
  logic [NB_COUNT-1:0] retired_q;

  // A flushed slot can neither retire nor halt the pipe.
  always_comb begin
    capture  = 1'b0;
    valid_in = i_MEM_valid & ~i_flush;
    state_d  = state_q;
    if (state_q == ST_RUN && i_enable) begin
      capture = 1'b1;
      if (valid_in && i_MEM_halt) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      sel_q        <= '0;
      retired_q    <= '0;
    end else if (capture) begin
      vld_q        <= valid_in;
      reg_write_q  <= i_MEM_reg_write & ~i_flush;
      mem_to_reg_q <= i_MEM_mem_to_reg;
      mem_data_q   <= i_MEM_mem_data;
      alu_result_q <= i_MEM_alu_result;
      sel_q        <= i_MEM_selected_reg;
      if (valid_in && retired_q != '1) retired_q <= retired_q + 1'b1;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic byte_q, half_q, uns_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      byte_q <= 1'b0;
      half_q <= 1'b0;
      uns_q  <= 1'b0;
    end else if (capture) begin
      byte_q <= i_MEM_byte_en;
      half_q <= i_MEM_halfword_en;
      uns_q  <= i_MEM_unsigned;
    end
  end

  wb_load_extend #(.NB_DATA(NB_DATA)) u_ext (
    .data        (mem_data_q),
    .byte_en     (byte_q),
    .halfword_en (half_q),
    .zero_ext    (uns_q),
    .ext_data    (mem_ext)
  );
`else
  logic unused_ext;
  assign unused_ext = &{1'b0, i_MEM_byte_en, i_MEM_halfword_en, i_MEM_unsigned};
  assign mem_ext    = mem_data_q;
`endif

  assign o_WB_data         = mem_to_reg_q ? mem_ext : alu_result_q;
  assign o_WB_selected_reg = sel_q;
  assign o_WB_reg_write    = vld_q & reg_write_q & (sel_q != NB_REG'(ZERO_REG_IDX));
  assign o_WB_valid        = vld_q;
  assign o_WB_halt         = (state_q == ST_HALTED);
  assign o_WB_retired      = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a behavioural model;
// a second NB_COUNT=4 instance on the same stimulus exercises counter saturation.
module tb_mem_wb_stage;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en, flush, valid, rw, m2r, be, he, uns, halt;
  logic [31:0] mdata, alu;
  logic [4:0]  sel;

  logic [31:0] d_data;
  logic [4:0]  d_reg;
  logic        d_we, d_valid, d_halt;
  logic [31:0] d_ret;

  logic [31:0] s_data;
  logic [4:0]  s_reg;
  logic        s_we, s_valid, s_halt;
  logic [3:0]  s_ret;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] m_data;
  logic [4:0]  m_reg;
  logic        m_we, m_valid, m_halted;
  longint      m_count;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_flush(flush),
    .i_MEM_valid(valid), .i_MEM_reg_write(rw), .i_MEM_mem_to_reg(m2r),
    .i_MEM_byte_en(be), .i_MEM_halfword_en(he), .i_MEM_unsigned(uns),
    .i_MEM_halt(halt), .i_MEM_mem_data(mdata), .i_MEM_alu_result(alu),
    .i_MEM_selected_reg(sel),
    .o_WB_data(d_data), .o_WB_selected_reg(d_reg), .o_WB_reg_write(d_we),
    .o_WB_valid(d_valid), .o_WB_halt(d_halt), .o_WB_retired(d_ret)
  );

  mem_wb_stage #(.NB_COUNT(4)) dut_sat (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_flush(flush),
    .i_MEM_valid(valid), .i_MEM_reg_write(rw), .i_MEM_mem_to_reg(m2r),
    .i_MEM_byte_en(be), .i_MEM_halfword_en(he), .i_MEM_unsigned(uns),
    .i_MEM_halt(halt), .i_MEM_mem_data(mdata), .i_MEM_alu_result(alu),
    .i_MEM_selected_reg(sel),
    .o_WB_data(s_data), .o_WB_selected_reg(s_reg), .o_WB_reg_write(s_we),
    .o_WB_valid(s_valid), .o_WB_halt(s_halt), .o_WB_retired(s_ret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Load value as the register file should see it, computed numerically.
  function automatic logic [31:0] load_val(input logic [31:0] d, input logic b,
                                           input logic h, input logic u);
    longint v;
    v = d;
`ifdef WB_LOAD_EXT_EN
    if (b) begin
      v = d % 256;
      if (!u && v >= 128) v = v - 256;
    end else if (h) begin
      v = d % 65536;
      if (!u && v >= 32768) v = v - 65536;
    end
`endif
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_data = 0; m_reg = 0; m_we = 0; m_valid = 0; m_halted = 0; m_count = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},  d_data,  m_data);
    chk({tag, ".reg"},   d_reg,   m_reg);
    chk({tag, ".we"},    d_we,    m_we);
    chk({tag, ".valid"}, d_valid, m_valid);
    chk({tag, ".halt"},  d_halt,  m_halted);
    chk({tag, ".ret"},   d_ret,   m_count[31:0]);
    chk({tag, ".sat"},   s_ret,   (m_count > 15) ? 64'd15 : m_count);
    chk({tag, ".sdata"}, s_data,  m_data);
  endtask

  task automatic cycle(input string tag);
    logic v;
    @(posedge clk);
    if (rst_n && !m_halted && en) begin
      v       = valid & ~flush;
      m_valid = v;
      m_reg   = sel;
      m_we    = v && rw && sel != 0;
      m_data  = m2r ? load_val(mdata, be, he, uns) : alu;
      if (v) m_count++;
      if (v && halt) m_halted = 1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic f, input logic v, input logic w,
                       input logic mr, input logic b, input logic h, input logic u,
                       input logic hl, input logic [31:0] md, input logic [31:0] a,
                       input logic [4:0] s);
    en = e; flush = f; valid = v; rw = w; m2r = mr; be = b; he = h; uns = u;
    halt = hl; mdata = md; alu = a; sel = s;
  endtask

  task automatic drive_rand(input logic allow_halt);
    drive(($urandom_range(3) != 0), ($urandom_range(4) == 0), $urandom_range(1),
          $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
          $urandom_range(1), allow_halt & $urandom_range(1), $urandom, $urandom,
          5'($urandom_range(31)));
  endtask

  logic [31:0] exp_b_s, exp_b_u, exp_h_s, exp_w;
  logic [31:0] hold_data;
  longint      hold_cnt;

  initial begin
`ifdef WB_LOAD_EXT_EN
    exp_b_s = 32'hFFFF_FFF0; exp_b_u = 32'h0000_00F0; exp_h_s = 32'hFFFF_80F0;
`else
    exp_b_s = 32'h0000_80F0; exp_b_u = 32'h0000_80F0; exp_h_s = 32'h0000_80F0;
`endif
    exp_w = 32'h0000_80F0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // ALU write-back
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0000_1234, 5);
    cycle("alu");
    chk("alu_data", d_data, 32'h1234);
    chk("alu_reg", d_reg, 5);
    chk("alu_we", d_we, 1);
    chk("alu_ret", d_ret, 1);

    // sub-word loads of 0x80F0
    drive(1, 0, 1, 1, 1, 1, 0, 0, 0, 32'h0000_80F0, 0, 7);
    cycle("lb");  chk("lb_data", d_data, exp_b_s);
    drive(1, 0, 1, 1, 1, 1, 0, 1, 0, 32'h0000_80F0, 0, 7);
    cycle("lbu"); chk("lbu_data", d_data, exp_b_u);
    drive(1, 0, 1, 1, 1, 0, 1, 0, 0, 32'h0000_80F0, 0, 7);
    cycle("lh");  chk("lh_data", d_data, exp_h_s);
    drive(1, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0000_80F0, 0, 7);
    cycle("lw");  chk("lw_data", d_data, exp_w);

    // write to $0 is suppressed but still retires
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h55, 0);
    cycle("r0");
    chk("r0_we", d_we, 0);
    chk("r0_valid", d_valid, 1);
    chk("r0_ret", d_ret, 6);

    // flush beats halt
    drive(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 32'h77, 3);
    cycle("flush_halt");
    chk("fh_valid", d_valid, 0);
    chk("fh_halt", d_halt, 0);
    chk("fh_ret", d_ret, 6);

    // flush without enable holds
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h99, 9);
    cycle("pre_hold");
    hold_data = d_data;
    drive(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 32'hAA, 10);
    cycle("flush_noen");
    chk("hold_data", d_data, hold_data);
    chk("hold_valid", d_valid, 1);

    for (int i = 0; i < 150; i++) begin
      drive_rand(1'b0);
      cycle("rand");
    end

    // HALT retires, then everything freezes
    drive(1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 32'h4321, 12);
    cycle("halt");
    chk("halt_rise", d_halt, 1);
    chk("halt_valid", d_valid, 1);
    hold_cnt = m_count;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      en = 1'b1;
      cycle("halted");
    end
    chk("frozen_ret", d_ret, hold_cnt[31:0]);
    chk("frozen_data", d_data, 32'h4321);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hBEEF, 4);
    cycle("post_rst");
    chk("post_rst_valid", d_valid, 1);
    chk("post_rst_ret", d_ret, 1);

    for (int i = 0; i < 40; i++) begin
      drive_rand(1'b0);
      cycle("rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and write-back logic directly downstream of the MEM stage. Captures MEM results on each pipeline advance and selects ALU result or memory data for the register file. With the extension feature, it also sign- or zero-extends sub-word loads. Tracks retired instructions and the halt condition for the debug unit, freezing the pipeline tail once a halt instruction retires.

## Interface
Parameters:
- NB_DATA, 32, data/result width
- NB_REG, 5, register index width
- NB_COUNT, 32, retired-instruction counter width

Ports:
- i_clock  in  1  pipeline clock; all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline advance (debug step/run); capture only when 1
- i_flush  in  1  replace incoming instruction with a bubble
- i_MEM_valid  in  1  incoming slot holds a real instruction
- i_MEM_reg_write  in  1  instruction writes register file
- i_MEM_mem_to_reg  in  1  1 = memory data, 0 = ALU result
- i_MEM_byte_en  in  1  load is byte-sized
- i_MEM_halfword_en  in  1  load is halfword-sized
- i_MEM_unsigned  in  1  zero-extend sub-word load (LBU/LHU)
- i_MEM_halt  in  1  instruction is HALT
- i_MEM_mem_data  in  NB_DATA  data memory read value, loaded bytes in LSBs
- i_MEM_alu_result  in  NB_DATA  ALU result
- i_MEM_selected_reg  in  NB_REG  destination register
- o_WB_data  out  NB_DATA  value to write to register file
- o_WB_selected_reg  out  NB_REG  destination register
- o_WB_reg_write  out  1  register-file write strobe
- o_WB_valid  out  1  WB slot holds a real instruction
- o_WB_halt  out  1  sticky: HALT has retired
- o_WB_retired  out  NB_COUNT  retired-instruction count

## Operation
- FSM states:
  - RUN: normal operation.
  - HALTED: entered on capture of a valid, non-flushed HALT.
  - HALTED is left only by reset.
- Capture condition: state RUN and i_enable=1.
  - On capture, all i_MEM_* fields are registered.
  - Registered valid = i_MEM_valid & ~i_flush.
  - If i_flush=1, registered reg_write and halt are forced to 0.
- i_flush with i_enable=0 has no effect; the register holds.
- In HALTED, i_enable and i_flush are ignored and the registers hold.
- o_WB_reg_write = valid_q & reg_write_q & (selected_reg_q != 0). Writes to $0 are suppressed.
- o_WB_data = mem_to_reg_q ? extended(mem_data_q) : alu_result_q.
- Extension, applied only when the feature is compiled in:
  - byte: low 8 bits, extended to NB_DATA.
  - halfword: low 16 bits, extended.
  - Extension is sign or zero according to unsigned_q.
  - If neither byte nor halfword is set: word, passed unchanged.
  - If both are set: byte wins.
- o_WB_retired increments by 1 on every capture with registered valid=1, including the HALT itself.
  - Saturates at all-ones and never wraps.

## Timing
- Latency: 1 cycle. Inputs captured at edge N appear on o_WB_* after edge N.
- o_WB_data and o_WB_reg_write are combinational from registered fields only; no input-to-output path.
- o_WB_halt rises in the cycle after the HALT capture edge, together with o_WB_valid for that HALT.
- Simultaneous i_flush and i_MEM_halt: the flush wins, and the FSM stays in RUN.
- Reset (asynchronous, any state, including mid-run or HALTED):
  - FSM returns to RUN.
  - All registered fields are 0, so o_WB_data=0, o_WB_selected_reg=0, o_WB_reg_write=0, o_WB_valid=0.
  - o_WB_halt=0 and o_WB_retired=0.

## Configuration
- WB_LOAD_EXT_EN defined: byte/halfword sign/zero extension as in Operation.
- Not defined:
  - mem_data_q passes unchanged.
  - i_MEM_byte_en, i_MEM_halfword_en and i_MEM_unsigned are not registered and are ignored.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state encoding (RUN, HALTED)
  - default widths NB_DATA/NB_REG/NB_COUNT
  - the constant zero-register index
- One sub-module: wb_load_extend, a combinational extender with data/byte/halfword/unsigned in and extended data out.
- The FSM, pipeline register and counter stay in mem_wb_stage.

## Test plan
- Reset, then i_enable=1 with a valid ALU op: mem_to_reg=0, alu_result=0x0000_1234, reg=5, reg_write=1.
  - Next cycle: o_WB_data=0x1234, o_WB_selected_reg=5, o_WB_reg_write=1, o_WB_retired=1.
- Loads, with WB_LOAD_EXT_EN defined and mem_data=0x0000_80F0:
  - byte signed -> 0xFFFF_FFF0
  - byte unsigned -> 0x0000_00F0
  - halfword signed -> 0xFFFF_80F0
  - word -> 0x0000_80F0
- Without WB_LOAD_EXT_EN, the same loads all give 0x0000_80F0.
- Write to reg 0 with reg_write=1 -> o_WB_reg_write=0 and o_WB_valid=1; the counter still increments.
- Flush and enable together on a valid HALT -> o_WB_valid=0, o_WB_halt=0, FSM stays in RUN, counter unchanged.
- Flush with i_enable=0 -> outputs unchanged.
- Valid HALT captured -> o_WB_halt=1 next cycle.
  - 10 further enabled cycles with new inputs: outputs and counter frozen.
  - Assert i_reset mid-cycle: all outputs 0 immediately (asynchronous), FSM returns to RUN.
- Preload the counter near saturation with NB_COUNT=4: 20 valid captures -> o_WB_retired holds at 0xF.
